// File: rtl/kp_emu_pkg.sv
// Shared definitions for the keypad emulator: FSM state encoding, key-code
// field positions, bounce LFSR tap mask and bounce step period.
// Imported by keypad_emulator and bounce_lfsr.
package kp_emu_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_BNC = 3'd1,
    HOLD      = 3'd2,
    REL_BNC   = 3'd3,
    GAP       = 3'd4
  } kpState_t;

  // keyCode layout: [3:2] row index, [1:0] column index
  localparam int ROW_MSB = 3;
  localparam int ROW_LSB = 2;
  localparam int COL_MSB = 1;
  localparam int COL_LSB = 0;

  // Fibonacci taps 8,6,5,4 -> bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // LFSR advances once every BOUNCE_STEP clocks
  localparam int BOUNCE_STEP = 64;
  localparam int STEP_W      = $clog2(BOUNCE_STEP);

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Request / scan bus between a keypad scanner side and the keypad emulator.
// Ports: keyCode, pressReq, col (driven by master); row, busy, done,
//        reqDropped (driven by the emulator on the slave modport).
interface keypad_emulator_if;
  logic [3:0] keyCode;
  logic       pressReq;
  logic [3:0] col;
  logic [3:0] row;
  logic       busy;
  logic       done;
  logic       reqDropped;

  modport master (
    output keyCode, pressReq, col,
    input  row, busy, done, reqDropped
  );

  modport slave (
    input  keyCode, pressReq, col,
    output row, busy, done, reqDropped
  );
endinterface

// File: rtl/keypad_emulator_bounce_lfsr.sv
// 8-bit Fibonacci LFSR used as the contact-bounce noise source.
// Ports: clk, rst (async active low, loads seed), step (advance one state),
//        seed (reset value, must be non-zero), q (current state).
module bounce_lfsr
  import kp_emu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= seed;
    end else if (step) begin
      q <= {q[6:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// Keypad emulator: answers a 4x4 keypad scanner's column drive with row
// returns as if one key were held, with press bounce, hold, release bounce
// and an enforced gap. col->row latency 3 clk (2-flop sync + row register).
// Ports: clk, rst (async active low), bus (slave: keyCode, pressReq, col in;
//        row, busy, done, reqDropped out).
module keypad_emulator
  import kp_emu_pkg::*;
#(
  parameter int         BOUNCE_CYCLES = 250000,
  parameter int         HOLD_CYCLES   = 2500000,
  parameter int         GAP_CYCLES    = 2500000,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  keypad_emulator_if.slave  bus
);

  localparam int CNT_MAX = maxOf3(BOUNCE_CYCLES, HOLD_CYCLES, GAP_CYCLES);
  localparam int CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CW-1:0] BNC_LAST  = CW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  kpState_t         state;
  logic [CW-1:0]    cnt;
  logic [3:0]       keyLatched;
  logic [3:0]       colS1;
  logic [3:0]       colS2;
  logic [STEP_W-1:0] stepCnt;
  logic [7:0]       lfsrQ;
  logic             contact;
  logic [1:0]       keyR;
  logic [1:0]       keyC;

  assign keyR = keyLatched[ROW_MSB:ROW_LSB];
  assign keyC = keyLatched[COL_MSB:COL_LSB];

  // Free-running prescaler: the LFSR advances once per BOUNCE_STEP clocks,
  // independent of the FSM, so bounce patterns differ press to press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stepCnt <= '0;
    end else begin
      stepCnt <= stepCnt + 1'b1;
    end
  end

  bounce_lfsr uLfsr (
    .clk  (clk),
    .rst  (rst),
    .step (&stepCnt),
    .seed (LFSR_SEED),
    .q    (lfsrQ)
  );

  // Switch closure. The final cycle of each bounce window is forced to the
  // settled level so HOLD always starts closed and GAP always starts open.
  always_comb begin
    contact = 1'b0;
    case (state)
      PRESS_BNC: contact = (cnt == BNC_LAST) ? 1'b1 : lfsrQ[0];
      HOLD:      contact = 1'b1;
      REL_BNC:   contact = (cnt == BNC_LAST) ? 1'b0 : lfsrQ[0];
      default:   contact = 1'b0;
    endcase
  end

  // Column synchronizer and registered row return. Only the latched column
  // matters, so several low col bits behave like a real single-key matrix.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      colS1   <= 4'hF;
      colS2   <= 4'hF;
      bus.row <= 4'hF;
    end else begin
      colS1 <= bus.col;
      colS2 <= colS1;
      if (contact && !colS2[keyC]) begin
        bus.row <= ~(4'b0001 << keyR);
      end else begin
        bus.row <= 4'hF;
      end
    end
  end

  // Press sequencer. Counter restarts on every state entry; a state lasting
  // N cycles leaves when cnt == N-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      keyLatched     <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.reqDropped <= 1'b0;
    end else begin
      bus.done       <= 1'b0;
      bus.reqDropped <= 1'b0;
      cnt            <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.pressReq) begin
            keyLatched <= bus.keyCode;
            bus.busy   <= 1'b1;
            state      <= (BOUNCE_CYCLES == 0) ? HOLD : PRESS_BNC;
          end
        end
        PRESS_BNC: begin
          if (cnt == BNC_LAST) begin
            cnt   <= '0;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            state <= (BOUNCE_CYCLES == 0) ? GAP : REL_BNC;
          end
        end
        REL_BNC: begin
          if (cnt == BNC_LAST) begin
            cnt   <= '0;
            state <= GAP;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt      <= '0;
            state    <= IDLE;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
      // Includes the GAP->IDLE cycle: the request is still refused there.
      if (bus.pressReq && (state != IDLE)) begin
        bus.reqDropped <= 1'b1;
      end
    end
  end

endmodule
